// File: rtl/countdown_if.sv
// Handshake/status bundle for countdown_timer. The timer binds the slave modport;
// the controller (or bench) binds master. state exposes the FSM for checkers.
interface countdown_if;
  logic       tick;
  logic       load;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic       start;
  logic       hold;
  logic [5:0] min;
  logic [5:0] sec;
  logic       busy;
  logic       borrow;
  logic       done;
  logic       alarm;
  logic [1:0] state;

  modport master (
    output tick, load, load_min, load_sec, start, hold,
    input  min, sec, busy, borrow, done, alarm, state
  );

  modport slave (
    input  tick, load, load_min, load_sec, start, hold,
    output min, sec, busy, borrow, done, alarm, state
  );
endinterface

// File: rtl/countdown_timer.sv
// MM:SS countdown timer with IDLE/RUN/HOLD/EXPIRED control and a reload preset.
// Optional alarm output enabled by defining COUNTDOWN_ALARM_EN.
//
// Control semantics: inputs are levels sampled on every rising clk edge; tick is a
// one-cycle enable and is only honoured in RUN. load overrides everything else.
// All outputs come straight from flops, so borrow/done appear the cycle after the
// edge that performed the step.
module countdown_timer #(
  parameter int MAX_SEC = 59,
  parameter int MAX_MIN = 59
) (
  input  logic        clk,
  input  logic        rst,
  countdown_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  localparam logic [5:0] SEC_TOP = 6'(MAX_SEC);
  localparam logic [5:0] MIN_TOP = 6'(MAX_MIN);

  logic [1:0] state_q,   state_d;
  logic [5:0] min_q,     min_d;
  logic [5:0] sec_q,     sec_d;
  logic [5:0] pre_min_q, pre_min_d;
  logic [5:0] pre_sec_q, pre_sec_d;
  logic       busy_q,    busy_d;
  logic       borrow_q,  borrow_d;
  logic       done_q,    done_d;

  logic [5:0] load_min_sat;
  logic [5:0] load_sec_sat;
  logic       count_zero;
  logic       preset_zero;

  assign load_min_sat = (bus.load_min > MIN_TOP) ? MIN_TOP : bus.load_min;
  assign load_sec_sat = (bus.load_sec > SEC_TOP) ? SEC_TOP : bus.load_sec;
  assign count_zero   = (min_q == 6'd0) && (sec_q == 6'd0);
  assign preset_zero  = (pre_min_q == 6'd0) && (pre_sec_q == 6'd0);

  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    sec_d     = sec_q;
    pre_min_d = pre_min_q;
    pre_sec_d = pre_sec_q;
    borrow_d  = 1'b0;
    done_d    = 1'b0;

    if (bus.load) begin
      min_d     = load_min_sat;
      sec_d     = load_sec_sat;
      pre_min_d = load_min_sat;
      pre_sec_d = load_sec_sat;
      state_d   = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && !count_zero) state_d = S_RUN;
        end
        S_RUN: begin
          // hold wins over a coincident tick: no step is taken on that edge
          if (bus.hold) begin
            state_d = S_HOLD;
          end else if (bus.tick) begin
            if (sec_q != 6'd0) begin
              sec_d = sec_q - 6'd1;
              if ((min_q == 6'd0) && (sec_q == 6'd1)) begin
                state_d = S_EXPIRED;
                done_d  = 1'b1;
              end
            end else if (min_q != 6'd0) begin
              sec_d    = SEC_TOP;
              min_d    = min_q - 6'd1;
              borrow_d = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (!bus.hold) state_d = S_RUN;
        end
        S_EXPIRED: begin
          if (bus.start) begin
            min_d   = pre_min_q;
            sec_d   = pre_sec_q;
            state_d = preset_zero ? S_IDLE : S_RUN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_RUN) || (state_d == S_HOLD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      min_q     <= 6'd0;
      sec_q     <= 6'd0;
      pre_min_q <= 6'd0;
      pre_sec_q <= 6'd0;
      busy_q    <= 1'b0;
      borrow_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      pre_min_q <= pre_min_d;
      pre_sec_q <= pre_sec_d;
      busy_q    <= busy_d;
      borrow_q  <= borrow_d;
      done_q    <= done_d;
    end
  end

`ifdef COUNTDOWN_ALARM_EN
  logic alarm_q, alarm_d;

  assign alarm_d = (state_d == S_EXPIRED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) alarm_q <= 1'b0;
    else      alarm_q <= alarm_d;
  end

  assign bus.alarm = alarm_q;
`else
  assign bus.alarm = 1'b0;
`endif

  assign bus.min    = min_q;
  assign bus.sec    = sec_q;
  assign bus.busy   = busy_q;
  assign bus.borrow = borrow_q;
  assign bus.done   = done_q;
  assign bus.state  = state_q;

endmodule
